branch_predict_unit: RTL and testbench

Parametrised successor to the core's branch/jump handler. It adds a 2-bit bimodal branch history table (BHT) that predicts direction at decode. Branch conditions are resolved internally from register operands, including the unsigned compares. On a wrong prediction it issues a single-cycle registered redirect, and it keeps saturating branch and mispredict statistics counters. It sits between the ID and EX stages and drives the fetch PC mux and the link-register writeback.

---
 rtl/branch_predict_unit_if.sv | 39 +++
 rtl/branch_predict_unit.sv | 97 +++++++++
 tb/tb_branch_predict_unit.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predict_unit_if.sv
// ID/EX-side signal bundle for the branch predict unit.
// The slave modport is the unit's view; the master modport is the pipeline's view.
interface branch_predict_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic            stall;
  logic            id_valid, id_b_type, id_jal;
  logic [XLEN-1:0] id_pc, id_imm;
  logic            id_pred_taken;
  logic [XLEN-1:0] id_pred_target;
  logic            ex_valid, ex_b_type, ex_jal, ex_jalr;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_rs1, ex_rs2, ex_imm, ex_pc;
  logic            ex_pred_taken;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            misalign;
  logic            link_we;
  logic [XLEN-1:0] link_data;
  logic            stats_clr;
  logic [CNT_W-1:0] br_cnt, mis_cnt;

  modport slave (
    input  stall, id_valid, id_b_type, id_jal, id_pc, id_imm,
           ex_valid, ex_b_type, ex_jal, ex_jalr, ex_funct3, ex_rs1, ex_rs2,
           ex_imm, ex_pc, ex_pred_taken, stats_clr,
    output id_pred_taken, id_pred_target, redirect, redirect_pc, misalign,
           link_we, link_data, br_cnt, mis_cnt
  );

  modport master (
    output stall, id_valid, id_b_type, id_jal, id_pc, id_imm,
           ex_valid, ex_b_type, ex_jal, ex_jalr, ex_funct3, ex_rs1, ex_rs2,
           ex_imm, ex_pc, ex_pred_taken, stats_clr,
    input  id_pred_taken, id_pred_target, redirect, redirect_pc, misalign,
           link_we, link_data, br_cnt, mis_cnt
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor plus EX-stage branch/jump resolver: predicts at ID,
// resolves at EX, issues a one-cycle registered redirect and keeps statistics.
module branch_predict_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 16
) (
  input logic                  clk,
  input logic                  rstB,
  branch_predict_unit_if.slave bus
);
  localparam int IW = $clog2(BHT_DEPTH);

  logic [BHT_DEPTH-1:0][1:0] bht_q;
  logic                      redirect_q, misalign_q, link_we_q;
  logic [XLEN-1:0]           redirect_pc_q, link_data_q;
  logic [CNT_W-1:0]          br_cnt_q, mis_cnt_q;

  logic [IW-1:0]   id_idx, ex_idx;
  logic            accept, cond, taken, mispred;
  logic [XLEN-1:0] pc4, br_tgt, jalr_sum, target;
  logic            redirect_d, misalign_d, link_we_d;
  logic [XLEN-1:0] redirect_pc_d;

  assign id_idx = bus.id_pc[IW+1:2];
  assign ex_idx = bus.ex_pc[IW+1:2];

  assign bus.id_pred_taken  = bus.id_valid & (bus.id_jal | (bus.id_b_type & bht_q[id_idx][1]));
  assign bus.id_pred_target = bus.id_pc + bus.id_imm;

  always_comb begin
    // The cycle carrying redirect is the flush shadow; EX contents there are stale.
    accept   = bus.ex_valid & ~bus.stall & ~redirect_q;
    cond     = 1'b0;
    case (bus.ex_funct3)
      3'b000:  cond = (bus.ex_rs1 == bus.ex_rs2);
      3'b001:  cond = (bus.ex_rs1 != bus.ex_rs2);
      3'b100:  cond = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
      3'b101:  cond = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
      3'b110:  cond = (bus.ex_rs1 <  bus.ex_rs2);
      3'b111:  cond = (bus.ex_rs1 >= bus.ex_rs2);
      default: cond = 1'b0;
    endcase
    pc4      = bus.ex_pc + XLEN'(4);
    br_tgt   = bus.ex_pc + bus.ex_imm;
    jalr_sum = bus.ex_rs1 + bus.ex_imm;
    target   = bus.ex_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : br_tgt;
    taken    = bus.ex_jal | bus.ex_jalr | (bus.ex_b_type & cond);
    // No target prediction exists, so every JALR redirects.
    if (bus.ex_jalr)        mispred = 1'b1;
    else if (bus.ex_jal)    mispred = ~bus.ex_pred_taken;
    else if (bus.ex_b_type) mispred = taken ^ bus.ex_pred_taken;
    else                    mispred = 1'b0;
    redirect_d    = accept & mispred;
    misalign_d    = accept & taken & target[1];
    link_we_d     = accept & (bus.ex_jal | bus.ex_jalr);
    redirect_pc_d = taken ? target : pc4;
  end

  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      bht_q         <= {BHT_DEPTH{2'b01}};
      redirect_q    <= 1'b0;
      misalign_q    <= 1'b0;
      link_we_q     <= 1'b0;
      redirect_pc_q <= '0;
      link_data_q   <= '0;
      br_cnt_q      <= '0;
      mis_cnt_q     <= '0;
    end else begin
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
      link_we_q  <= link_we_d;
      if (accept) begin
        redirect_pc_q <= redirect_pc_d;
        link_data_q   <= pc4;
      end
      if (accept && bus.ex_b_type) begin
        if (taken && bht_q[ex_idx] != 2'b11)       bht_q[ex_idx] <= bht_q[ex_idx] + 2'b01;
        else if (!taken && bht_q[ex_idx] != 2'b00) bht_q[ex_idx] <= bht_q[ex_idx] - 2'b01;
      end
      // Clear beats a coincident increment.
      if (bus.stats_clr)                                         br_cnt_q <= '0;
      else if (accept && bus.ex_b_type && br_cnt_q != '1)        br_cnt_q <= br_cnt_q + 1'b1;
      if (bus.stats_clr)                                         mis_cnt_q <= '0;
      else if (redirect_d && mis_cnt_q != '1)                    mis_cnt_q <= mis_cnt_q + 1'b1;
    end
  end

  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.misalign    = misalign_q;
  assign bus.link_we     = link_we_q;
  assign bus.link_data   = link_data_q;
  assign bus.br_cnt      = br_cnt_q;
  assign bus.mis_cnt     = mis_cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural reference model.
module tb_branch_predict_unit;
  localparam int CW    = 4;
  localparam int DEPTH = 16;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rstB = 1'b0;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.XLEN(32), .CNT_W(CW)) bus ();
  branch_predict_unit #(.XLEN(32), .BHT_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rstB(rstB), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_bht [DEPTH];
  int          m_br, m_mis;
  logic        m_red, m_mal, m_lwe;
  logic [31:0] m_rpc, m_ldata;
  int          n_bht [DEPTH];
  int          n_br, n_mis;
  logic        n_red, n_mal, n_lwe;
  logic [31:0] n_rpc, n_ldata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
    m_br = 0; m_mis = 0; m_red = 0; m_mal = 0; m_lwe = 0; m_rpc = 0; m_ldata = 0;
  endtask

  function automatic logic model_pred();
    return bus.id_valid && (bus.id_jal || (bus.id_b_type && m_bht[bus.id_pc[5:2]] >= 2));
  endfunction

  task automatic model_eval();
    logic acc, c, tk, mp;
    logic [31:0] tgt;
    int ix;
    n_bht = m_bht; n_br = m_br; n_mis = m_mis; n_rpc = m_rpc; n_ldata = m_ldata;
    acc = bus.ex_valid && !bus.stall && !m_red;
    case (bus.ex_funct3)
      3'd0: c = bus.ex_rs1 == bus.ex_rs2;
      3'd1: c = bus.ex_rs1 != bus.ex_rs2;
      3'd4: c = $signed(bus.ex_rs1) < $signed(bus.ex_rs2);
      3'd5: c = $signed(bus.ex_rs1) >= $signed(bus.ex_rs2);
      3'd6: c = bus.ex_rs1 < bus.ex_rs2;
      3'd7: c = bus.ex_rs1 >= bus.ex_rs2;
      default: c = 1'b0;
    endcase
    tk  = bus.ex_jal || bus.ex_jalr || (bus.ex_b_type && c);
    tgt = bus.ex_jalr ? ((bus.ex_rs1 + bus.ex_imm) & 32'hFFFF_FFFE) : bus.ex_pc + bus.ex_imm;
    mp  = bus.ex_jalr ? 1'b1 : bus.ex_jal ? !bus.ex_pred_taken :
          bus.ex_b_type ? (tk != bus.ex_pred_taken) : 1'b0;
    n_red = acc && mp;
    n_mal = acc && tk && tgt[1];
    n_lwe = acc && (bus.ex_jal || bus.ex_jalr);
    if (acc) begin
      n_rpc   = tk ? tgt : bus.ex_pc + 32'd4;
      n_ldata = bus.ex_pc + 32'd4;
    end
    ix = int'(bus.ex_pc[5:2]);
    if (acc && bus.ex_b_type) n_bht[ix] = tk ? ((m_bht[ix] + 1 > 3) ? 3 : m_bht[ix] + 1)
                                             : ((m_bht[ix] - 1 < 0) ? 0 : m_bht[ix] - 1);
    if (bus.stats_clr) begin
      n_br = 0; n_mis = 0;
    end else begin
      if (acc && bus.ex_b_type && n_br < CMAX) n_br++;
      if (n_red && n_mis < CMAX) n_mis++;
    end
  endtask

  // Advance one clock, update the model, and compare every registered output.
  task automatic tick();
    model_eval();
    @(posedge clk); #1;
    m_bht = n_bht; m_br = n_br; m_mis = n_mis; m_red = n_red; m_mal = n_mal;
    m_lwe = n_lwe; m_rpc = n_rpc; m_ldata = n_ldata;
    chk("redirect",    32'(bus.redirect), 32'(m_red));
    chk("redirect_pc", bus.redirect_pc,   m_rpc);
    chk("misalign",    32'(bus.misalign), 32'(m_mal));
    chk("link_we",     32'(bus.link_we),  32'(m_lwe));
    chk("link_data",   bus.link_data,     m_ldata);
    chk("br_cnt",      32'(bus.br_cnt),   32'(m_br));
    chk("mis_cnt",     32'(bus.mis_cnt),  32'(m_mis));
  endtask

  task automatic idle();
    bus.stall = 0; bus.stats_clr = 0;
    bus.id_valid = 0; bus.id_b_type = 0; bus.id_jal = 0; bus.id_pc = 0; bus.id_imm = 0;
    bus.ex_valid = 0; bus.ex_b_type = 0; bus.ex_jal = 0; bus.ex_jalr = 0; bus.ex_funct3 = 0;
    bus.ex_rs1 = 0; bus.ex_rs2 = 0; bus.ex_imm = 0; bus.ex_pc = 0; bus.ex_pred_taken = 0;
  endtask

  task automatic ex_set(input logic b, input logic j, input logic jr, input logic [2:0] f3,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic [31:0] pc, input logic pred);
    bus.ex_valid = 1; bus.ex_b_type = b; bus.ex_jal = j; bus.ex_jalr = jr; bus.ex_funct3 = f3;
    bus.ex_rs1 = rs1; bus.ex_rs2 = rs2; bus.ex_imm = imm; bus.ex_pc = pc; bus.ex_pred_taken = pred;
  endtask

  typedef struct {
    logic b, j, jr; logic [2:0] f3; logic [31:0] rs1, rs2, imm, pc; logic pred;
    logic e_red; logic [31:0] e_rpc; logic e_mal, e_lwe;
  } vec_t;
  vec_t vecs [9];

  initial begin
    vecs[0] = '{1,0,0,3'd6,32'hFFFF_FFFF,32'd1,32'h40,32'h100,0, 0,32'h104,0,0}; // BLTU nt
    vecs[1] = '{1,0,0,3'd4,32'hFFFF_FFFF,32'd1,32'h40,32'h100,0, 1,32'h140,0,0}; // BLT t
    vecs[2] = '{0,0,1,3'd0,32'h1003,32'd0,32'h0,32'h200,1,        1,32'h1002,1,1}; // JALR
    vecs[3] = '{1,0,0,3'd1,32'd3,32'd3,32'h8,32'h300,1,           1,32'h304,0,0}; // BNE nt
    vecs[4] = '{1,0,0,3'd5,32'hFFFF_FFFF,32'd1,32'h10,32'h400,0, 0,32'h404,0,0}; // BGE nt
    vecs[5] = '{1,0,0,3'd7,32'hFFFF_FFFF,32'd1,32'h10,32'h400,1, 0,32'h410,0,0}; // BGEU t
    vecs[6] = '{0,1,0,3'd0,32'd0,32'd0,32'h102,32'h500,1,         0,32'h602,1,1}; // JAL ok, misaligned
    vecs[7] = '{1,0,0,3'd2,32'd0,32'd0,32'h20,32'h600,1,          1,32'h604,0,0}; // funct3 010
    vecs[8] = '{0,1,0,3'd0,32'd0,32'd0,32'hFFFF_FFF8,32'h700,0,   1,32'h6F8,0,1}; // JAL backward

    idle();
    model_reset();
    #12;
    chk("rst_redirect",    32'(bus.redirect), 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc,   32'd0);
    chk("rst_link_data",   bus.link_data,     32'd0);
    chk("rst_mis_cnt",     32'(bus.mis_cnt),  32'd0);
    rstB = 1;
    @(posedge clk); #1;

    // Prediction out of reset: weakly not-taken
    bus.id_valid = 1; bus.id_b_type = 1; bus.id_pc = 32'h100; bus.id_imm = 32'h44; #1;
    chk("pred_reset",  32'(bus.id_pred_taken), 32'd0);
    chk("pred_target", bus.id_pred_target,     32'h144);
    bus.id_b_type = 0; bus.id_jal = 1; #1;
    chk("pred_jal", 32'(bus.id_pred_taken), 32'd1);
    bus.id_jal = 0; bus.id_b_type = 1;

    // BEQ taken, predicted not-taken, three times; BHT[0] saturates toward taken
    for (int k = 0; k < 3; k++) begin
      ex_set(1,0,0,3'd0,32'd5,32'd5,32'h20,32'h100,0);
      tick();
      if (k == 0) begin
        chk("beq_redirect", 32'(bus.redirect), 32'd1);
        chk("beq_rpc",      bus.redirect_pc,   32'h120);
        chk("beq_mis",      32'(bus.mis_cnt),  32'd1);
        chk("beq_br",       32'(bus.br_cnt),   32'd1);
      end
      idle(); bus.id_valid = 1; bus.id_b_type = 1; bus.id_pc = 32'h100;
      tick();
    end
    #1;
    chk("pred_trained", 32'(bus.id_pred_taken), 32'd1);
    chk("beq_br3",      32'(bus.br_cnt),        32'd3);
    chk("beq_mis3",     32'(bus.mis_cnt),       32'd3);
    bus.stats_clr = 1; idle(); bus.stats_clr = 1; tick(); idle();

    // Directed vector table; an idle cycle after each clears the shadow
    for (int v = 0; v < 9; v++) begin
      ex_set(vecs[v].b, vecs[v].j, vecs[v].jr, vecs[v].f3, vecs[v].rs1, vecs[v].rs2,
             vecs[v].imm, vecs[v].pc, vecs[v].pred);
      tick();
      chk($sformatf("vec%0d_redirect", v), 32'(bus.redirect), 32'(vecs[v].e_red));
      chk($sformatf("vec%0d_rpc", v),      bus.redirect_pc,   vecs[v].e_rpc);
      chk($sformatf("vec%0d_misalign", v), 32'(bus.misalign), 32'(vecs[v].e_mal));
      chk($sformatf("vec%0d_link_we", v),  32'(bus.link_we),  32'(vecs[v].e_lwe));
      chk($sformatf("vec%0d_link", v),     bus.link_data,     vecs[v].pc + 32'd4);
      idle(); tick();
    end

    // Shadow cycle: the instruction following a redirect is dropped
    bus.stats_clr = 1; tick(); idle();
    ex_set(0,0,1,3'd0,32'h40,32'd0,32'd0,32'h800,0);
    tick();
    chk("shadow_first", 32'(bus.redirect), 32'd1);
    ex_set(1,0,0,3'd0,32'd1,32'd1,32'h10,32'h804,0);
    tick();
    chk("shadow_redirect", 32'(bus.redirect), 32'd0);
    chk("shadow_link_we",  32'(bus.link_we),  32'd0);
    chk("shadow_br",       32'(bus.br_cnt),   32'd0);
    chk("shadow_mis",      32'(bus.mis_cnt),  32'd1);
    idle(); tick();

    // Stall suppresses capture, BHT update and counting
    ex_set(1,0,0,3'd0,32'd1,32'd1,32'h10,32'h110,0);
    bus.stall = 1;
    tick();
    chk("stall_redirect", 32'(bus.redirect), 32'd0);
    chk("stall_br",       32'(bus.br_cnt),   32'd0);
    idle(); bus.id_valid = 1; bus.id_b_type = 1; bus.id_pc = 32'h110; #1;
    chk("stall_bht", 32'(bus.id_pred_taken), 32'd0);
    idle();

    // Mispredict counter saturation, then clear racing a mispredict
    ex_set(0,0,1,3'd0,32'h40,32'd0,32'd0,32'h900,0);
    for (int k = 0; k < 2 * CMAX + 4; k++) tick();
    chk("mis_sat", 32'(bus.mis_cnt), 32'(CMAX));
    idle(); tick();
    ex_set(0,0,1,3'd0,32'h40,32'd0,32'd0,32'h900,0);
    bus.stats_clr = 1;
    tick();
    chk("clr_wins", 32'(bus.mis_cnt), 32'd0);
    chk("clr_redirect", 32'(bus.redirect), 32'd1);
    idle(); tick();

    // Reset asserted while a redirect pulse is high
    ex_set(0,0,1,3'd0,32'h44,32'd0,32'd0,32'hA00,0);
    tick();
    chk("pre_rst_redirect", 32'(bus.redirect), 32'd1);
    rstB = 0; #1;
    model_reset();
    chk("midrst_redirect", 32'(bus.redirect), 32'd0);
    chk("midrst_link_we",  32'(bus.link_we),  32'd0);
    chk("midrst_rpc",      bus.redirect_pc,   32'd0);
    idle(); #2; rstB = 1;
    @(posedge clk); #1;

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] opnd [5];
      int ty;
      opnd[0] = 0; opnd[1] = 1; opnd[2] = 5; opnd[3] = 32'hFFFF_FFFF; opnd[4] = 32'h8000_0000;
      ty = $urandom_range(0, 5);
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.stats_clr = ($urandom_range(0, 40) == 0);
      bus.ex_valid = ($urandom_range(0, 5) != 0);
      bus.ex_b_type = (ty <= 2); bus.ex_jal = (ty == 3); bus.ex_jalr = (ty == 4);
      bus.ex_funct3 = 3'($urandom);
      bus.ex_rs1 = opnd[$urandom_range(0, 4)];
      bus.ex_rs2 = opnd[$urandom_range(0, 4)];
      bus.ex_imm = 32'($signed(12'($urandom)));
      bus.ex_pc = 32'h100 + ($urandom_range(0, 31) << 2);
      bus.ex_pred_taken = 1'($urandom);
      bus.id_valid = 1'($urandom); bus.id_b_type = 1'($urandom); bus.id_jal = ($urandom_range(0, 3) == 0);
      bus.id_pc = 32'h100 + ($urandom_range(0, 31) << 2);
      bus.id_imm = $urandom;
      #1;
      chk("rnd_pred",   32'(bus.id_pred_taken), 32'(model_pred()));
      chk("rnd_target", bus.id_pred_target,     bus.id_pc + bus.id_imm);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end
endmodule
